apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB initiator that drives the shared APB bus that our per-peripheral APB slaves sit on.
//  - Accepts single read/write commands from a local controller (CPU model or test sequencer).
//  - Runs each command as one SETUP/ACCESS transfer to the slave selected by its encoded id.
//  - Waits on slave ready and returns read data or a timeout error on a one-cycle response strobe.
// PARAMETERS
//  ADDR_W   8    address width (addr, cmd_addr)
//  DATA_W   8    data width (wdata, rdata, cmd_wdata, rsp_rdata)
//  TIMEOUT  255  max ACCESS cycles with ready low before abort (1..255)
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  reset      in   1       asynchronous, active-high reset
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       command accepted on clk edge when cmd_valid && cmd_ready
//  cmd_write  in   1       1=write, 0=read
//  cmd_id     in   2       target slave id; 0 = no slave (illegal)
//  cmd_addr   in   ADDR_W  transfer address
//  cmd_wdata  in   DATA_W  write data
//  rsp_valid  out  1       one-cycle pulse: command finished
//  rsp_error  out  1       qualified by rsp_valid: 1 = timeout or illegal id
//  rsp_rdata  out  DATA_W  qualified by rsp_valid && !rsp_error && read
//  sel        out  2       APB select, encoded slave id; 0 = bus idle
//  enable     out  1       APB enable (ACCESS phase)
//  write      out  1       APB direction
//  addr       out  ADDR_W  APB address
//  wdata      out  DATA_W  APB write data
//  rdata      in   DATA_W  APB read data from the selected slave
//  ready      in   1       APB ready from the selected slave
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async, any time including mid-transfer):
//    - state=IDLE; sel=0, enable=0, write=0, addr=0, wdata=0.
//    - rsp_valid=0, rsp_error=0, rsp_rdata=0, wait counter=0.
//    - cmd_ready=1 from the first edge after reset deasserts.
//    - An in-flight transfer is dropped with no response.
//  - FSM states: IDLE, SETUP, ACCESS, RESP.
//  - IDLE:
//    - cmd_ready=1, sel=0, enable=0.
//    - On accept with cmd_id!=0: latch cmd_write/id/addr/wdata, go to SETUP.
//    - On accept with cmd_id==0: no bus activity, go to RESP with error=1.
//  - SETUP (exactly 1 cycle):
//    - sel=id, write, addr and wdata driven; enable=0; cmd_ready=0.
//    - Go to ACCESS.
//  - ACCESS:
//    - enable=1; sel/addr/write/wdata held stable; counter increments each cycle ready=0.
//    - ready=1 sampled: capture rdata into rsp_rdata on reads; error=0; go to RESP.
//    - Counter reaches TIMEOUT with ready=0: error=1, rsp_rdata=0; go to RESP.
//    - ready is ignored in IDLE and SETUP; slaves may hold ready high while idle.
//  - RESP (exactly 1 cycle):
//    - rsp_valid=1; sel=0, enable=0, counter cleared; go to IDLE.
//    - No response backpressure.
//    - rsp_rdata holds its value until the next response.
//  - Latency:
//    - Command accepted at edge E0 -> SETUP after E0, ACCESS after E1.
//    - Zero-wait slave -> rsp_valid in the cycle after E2.
//    - N wait cycles add N cycles.
//    - Minimum 4 cycles per command: one outstanding command, no pipelining.
//  - Writes: rsp_rdata unchanged. Counter width 8 bits, saturating, no wrap.
//  - cmd_* inputs are sampled only at accept; later changes have no effect.
// TESTING
//  1 Write id=2 addr=0x10 wdata=0xA5, ready=1 in ACCESS:
//    -> SETUP sel=2 write=1 enable=0 addr=0x10 wdata=0xA5; ACCESS enable=1;
//    -> rsp_valid, rsp_error=0 in the cycle after ACCESS.
//  2 Read id=1 addr=0x04, slave rdata=0x3C, ready low 3 ACCESS cycles:
//    -> enable high 4 cycles, signals stable; rsp_rdata=0x3C, rsp_error=0.
//  3 Read id=3, ready never high, TIMEOUT=5:
//    -> abort after 5 ACCESS cycles; rsp_valid=1, rsp_error=1, rsp_rdata=0; sel=0.
//  4 Command cmd_id=0:
//    -> sel stays 0 throughout; rsp_valid with rsp_error=1 one cycle after accept.
//  5 Assert reset during ACCESS of a write:
//    -> sel/enable go 0 immediately (async); no rsp_valid;
//    -> next command proceeds normally.
//  6 cmd_valid held high with 3 queued commands:
//    -> cmd_ready only in IDLE; exactly 3 responses in order; ready=1 in IDLE ignored.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB initiator: takes one local read/write command at a time and runs it as a
// SETUP/ACCESS transfer, returning read data or an error on a one-cycle strobe.
module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_id,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_error,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        sel,
    output logic              enable,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              cmd_ready_nxt;
    logic              rsp_valid_nxt;
    logic              rsp_error_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic [1:0]        sel_nxt;
    logic              enable_nxt;
    logic              write_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [7:0]        wait_cnt, wait_cnt_nxt, wait_inc;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            sel       <= 2'd0;
            enable    <= 1'b0;
            write     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            wait_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_error <= rsp_error_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            sel       <= sel_nxt;
            enable    <= enable_nxt;
            write     <= write_nxt;
            addr      <= addr_nxt;
            wdata     <= wdata_nxt;
            wait_cnt  <= wait_cnt_nxt;
        end
    end

    // Every output is computed one cycle ahead so the registers above present
    // the value that belongs to the state being entered.
    always_comb begin
        state_nxt     = state;
        rsp_valid_nxt = 1'b0;
        rsp_error_nxt = rsp_error;
        rsp_rdata_nxt = rsp_rdata;
        sel_nxt       = sel;
        enable_nxt    = enable;
        write_nxt     = write;
        addr_nxt      = addr;
        wdata_nxt     = wdata;
        wait_cnt_nxt  = wait_cnt;
        wait_inc      = sat_inc(wait_cnt);

        case (state)
            IDLE: begin
                sel_nxt    = 2'd0;
                enable_nxt = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    if (cmd_id != 2'd0) begin
                        state_nxt = SETUP;
                        sel_nxt   = cmd_id;
                        write_nxt = cmd_write;
                        addr_nxt  = cmd_addr;
                        wdata_nxt = cmd_wdata;
                    end else begin
                        // No slave to address: answer with an error, bus stays idle.
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_error_nxt = 1'b1;
                        rsp_rdata_nxt = '0;
                    end
                end
            end
            SETUP: begin
                state_nxt    = ACCESS;
                enable_nxt   = 1'b1;
                wait_cnt_nxt = 8'd0;
            end
            ACCESS: begin
                if (ready) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_error_nxt = 1'b0;
                    if (!write)
                        rsp_rdata_nxt = rdata;
                    sel_nxt       = 2'd0;
                    enable_nxt    = 1'b0;
                    wait_cnt_nxt  = 8'd0;
                end else if (wait_inc >= TMO) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_error_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    sel_nxt       = 2'd0;
                    enable_nxt    = 1'b0;
                    wait_cnt_nxt  = 8'd0;
                end else begin
                    wait_cnt_nxt = wait_inc;
                end
            end
            RESP: begin
                state_nxt    = IDLE;
                sel_nxt      = 2'd0;
                enable_nxt   = 1'b0;
                wait_cnt_nxt = 8'd0;
            end
            default: begin
                state_nxt  = IDLE;
                sel_nxt    = 2'd0;
                enable_nxt = 1'b0;
            end
        endcase

        cmd_ready_nxt = (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: single transfers, wait states, timeout,
// illegal id, mid-transfer reset and back-to-back commands.
module tb_apb_master_bridge;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_id;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_error;
    logic [7:0] rsp_rdata;
    logic [1:0] sel;
    logic       enable;
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ready;

    logic       model_en;
    logic [7:0] rdata_v;
    assign rdata = model_en ? (addr ^ 8'hC3) : rdata_v;

    int n_cmp = 0;
    int n_err = 0;

    apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(5)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Presents a command and returns just after the accepting edge (SETUP cycle).
    task automatic issue(input logic w, input logic [1:0] id, input logic [7:0] a,
                         input logic [7:0] d);
        bit got;
        got       = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_id    = id;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL issue_accept got cmd_ready=0 want 1 within 20 cycles");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (sel !== 2'd0 || enable !== 1'b0 || write !== 1'b0) begin
            n_err++; $display("FAIL rst_bus got sel=%0d en=%0b wr=%0b want 0 0 0", sel, enable, write); end
        n_cmp++; if (addr !== 8'h00 || wdata !== 8'h00) begin
            n_err++; $display("FAIL rst_addr_data got %0h %0h want 0 0", addr, wdata); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 8'h00) begin
            n_err++; $display("FAIL rst_rsp got v=%0b e=%0b d=%0h want 0 0 0", rsp_valid, rsp_error, rsp_rdata); end
        n_cmp++; if (cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_cmd_ready got %0b want 0", cmd_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_ready_after got %0b want 1", cmd_ready); end
    endtask

    task automatic test_write;
        ready = 1'b1;
        issue(1'b1, 2'd2, 8'h10, 8'hA5);
        n_cmp++; if (sel !== 2'd2 || write !== 1'b1 || enable !== 1'b0) begin
            n_err++; $display("FAIL wr_setup got sel=%0d wr=%0b en=%0b want 2 1 0", sel, write, enable); end
        n_cmp++; if (addr !== 8'h10 || wdata !== 8'hA5 || cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL wr_setup_ad got a=%0h d=%0h rdy=%0b want 10 a5 0", addr, wdata, cmd_ready); end
        @(posedge clk); #1;
        n_cmp++; if (enable !== 1'b1 || sel !== 2'd2 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL wr_access got en=%0b sel=%0d v=%0b want 1 2 0", enable, sel, rsp_valid); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 8'h00) begin
            n_err++; $display("FAIL wr_resp got v=%0b e=%0b d=%0h want 1 0 0", rsp_valid, rsp_error, rsp_rdata); end
        n_cmp++; if (sel !== 2'd0 || enable !== 1'b0) begin
            n_err++; $display("FAIL wr_resp_bus got sel=%0d en=%0b want 0 0", sel, enable); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL wr_idle got v=%0b rdy=%0b want 0 1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_read_wait;
        ready   = 1'b0;
        rdata_v = 8'h3C;
        issue(1'b0, 2'd1, 8'h04, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (enable !== 1'b1 || sel !== 2'd1 || addr !== 8'h04 || write !== 1'b0) begin
                n_err++; $display("FAIL rd_access[%0d] got en=%0b sel=%0d a=%0h wr=%0b want 1 1 04 0", i, enable, sel, addr, write); end
            if (i == 3) ready = 1'b1;
        end
        @(posedge clk); #1;
        ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 8'h3C) begin
            n_err++; $display("FAIL rd_resp got v=%0b e=%0b d=%0h want 1 0 3c", rsp_valid, rsp_error, rsp_rdata); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_rdata !== 8'h3C) begin
            n_err++; $display("FAIL rd_hold got %0h want 3c", rsp_rdata); end
    endtask

    task automatic test_timeout;
        ready = 1'b0;
        issue(1'b0, 2'd3, 8'h77, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (enable !== 1'b1 || rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL to_access[%0d] got en=%0b v=%0b want 1 0", i, enable, rsp_valid); end
        end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 8'h00 || sel !== 2'd0) begin
            n_err++; $display("FAIL to_resp got v=%0b e=%0b d=%0h sel=%0d want 1 1 0 0", rsp_valid, rsp_error, rsp_rdata, sel); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_id;
        ready = 1'b1;
        issue(1'b1, 2'd0, 8'h55, 8'h66);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || sel !== 2'd0 || enable !== 1'b0) begin
            n_err++; $display("FAIL id0_resp got v=%0b e=%0b sel=%0d en=%0b want 1 1 0 0", rsp_valid, rsp_error, sel, enable); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0 || sel !== 2'd0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL id0_after got v=%0b sel=%0d rdy=%0b want 0 0 1", rsp_valid, sel, cmd_ready); end
    endtask

    task automatic test_reset_midflight;
        bit seen;
        ready = 1'b0;
        issue(1'b1, 2'd2, 8'h20, 8'hBE);
        @(posedge clk); #1;
        n_cmp++; if (enable !== 1'b1) begin
            n_err++; $display("FAIL mid_access got en=%0b want 1", enable); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (sel !== 2'd0 || enable !== 1'b0) begin
            n_err++; $display("FAIL mid_async got sel=%0d en=%0b want 0 0", sel, enable); end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        n_cmp++; if (seen) begin
            n_err++; $display("FAIL mid_no_rsp got rsp_valid=1 want 0"); end
        ready   = 1'b1;
        rdata_v = 8'h5A;
        issue(1'b0, 2'd1, 8'h22, 8'h00);
        n_cmp++; if (sel !== 2'd1 || addr !== 8'h22) begin
            n_err++; $display("FAIL mid_next_setup got sel=%0d a=%0h want 1 22", sel, addr); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 8'h5A) begin
            n_err++; $display("FAIL mid_next_resp got v=%0b e=%0b d=%0h want 1 0 5a", rsp_valid, rsp_error, rsp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic       q_w [3];
        logic [1:0] q_id[3];
        logic [7:0] q_a [3];
        logic [7:0] q_d [3];
        logic [7:0] exp_d[3];
        int         acc_cyc[3];
        int         idx, nresp;
        bit         acc;
        q_w = '{1'b1, 1'b0, 1'b0};
        q_id = '{2'd1, 2'd2, 2'd3};
        q_a = '{8'h01, 8'h30, 8'h5A};
        q_d = '{8'h11, 8'h00, 8'h00};
        exp_d = '{8'h5A, 8'hF3, 8'h99};
        acc_cyc = '{0, 0, 0};
        model_en = 1'b1;
        ready = 1'b1;
        idx = 0; nresp = 0;
        cmd_valid = 1'b1;
        cmd_write = q_w[0]; cmd_id = q_id[0]; cmd_addr = q_a[0]; cmd_wdata = q_d[0];
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            n_cmp++; if (cmd_ready && (sel !== 2'd0 || enable !== 1'b0 || rsp_valid !== 1'b0)) begin
                n_err++; $display("FAIL b2b_ready_idle cyc %0d got sel=%0d en=%0b v=%0b with cmd_ready=1", cyc, sel, enable, rsp_valid); end
            if (rsp_valid) begin
                n_cmp++; if (nresp > 2 || rsp_error !== 1'b0 || rsp_rdata !== exp_d[nresp]) begin
                    n_err++; $display("FAIL b2b_resp[%0d] got e=%0b d=%0h want 0 %0h", nresp, rsp_error, rsp_rdata, exp_d[nresp % 3]); end
                nresp++;
            end
            acc = cmd_ready && cmd_valid;
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx == 3) cmd_valid = 1'b0;
                else begin
                    cmd_write = q_w[idx]; cmd_id = q_id[idx];
                    cmd_addr = q_a[idx];  cmd_wdata = q_d[idx];
                end
            end
            if (idx == 3 && nresp == 3) break;
        end
        model_en = 1'b0;
        n_cmp++; if (nresp !== 3 || idx !== 3) begin
            n_err++; $display("FAIL b2b_count got resp=%0d acc=%0d want 3 3", nresp, idx); end
        n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 4 || acc_cyc[2] - acc_cyc[1] !== 4) begin
            n_err++; $display("FAIL b2b_spacing got %0d %0d want 4 4", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = 2'd0;
        cmd_addr = 8'h00; cmd_wdata = 8'h00; ready = 1'b1;
        model_en = 1'b0; rdata_v = 8'h00;
        #3;
        test_reset;
        test_write;
        test_read_wait;
        test_timeout;
        test_illegal_id;
        test_reset_midflight;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
